// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - video SRAM arbiter: prioritised pixel reads, non-preemptible MCU writes
module sram_arbiter #(
    parameter int ADDRESS_WIDTH = 17,
    parameter int DATA_WIDTH    = 8,
    parameter int WRITE_CYCLES  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     videoReadRequest,
    input  logic [ADDRESS_WIDTH-1:0] videoReadAddress,
    output logic [DATA_WIDTH-1:0]    videoReadData,
    output logic                     videoReadValid,
    output logic                     videoReadOverrun,
    input  logic                     memoryWriteRequest,
    input  logic [ADDRESS_WIDTH-1:0] memoryAddress,
    input  logic [DATA_WIDTH-1:0]    memoryWriteData,
    output logic                     memoryWriteComplete,
    output logic [ADDRESS_WIDTH-1:0] sramAddress,
    output logic [DATA_WIDTH-1:0]    sramDataOut,
    output logic                     sramDataOutEnable,
    input  logic [DATA_WIDTH-1:0]    sramDataIn,
    output logic                     sramChipEnable_n,
    output logic                     sramOutputEnable_n,
    output logic                     sramWriteEnable_n
);

    typedef enum logic [2:0] {
        IDLE,
        READ_ADDR,
        READ_DATA,
        WRITE_SETUP,
        WRITE_PULSE,
        WRITE_HOLD,
        WRITE_DONE
    } stateType;

    localparam logic [2:0] LAST_PULSE = 3'(WRITE_CYCLES - 1);

    stateType                 state;
    stateType                 nextState;
    logic                     readPending;
    logic [ADDRESS_WIDTH-1:0] readPendingAddress;
    logic [2:0]               pulseCount;

    logic                     readWanted;
    logic                     readConsume;
    logic                     writeStart;
    logic [ADDRESS_WIDTH-1:0] readAddressNext;

    logic chipEnableNext_n;
    logic outputEnableNext_n;
    logic writeEnableNext_n;
    logic dataOutEnableNext;
    logic writeCompleteNext;

    // A request arriving this cycle is newer than anything already pending.
    assign readWanted      = readPending | videoReadRequest;
    assign readAddressNext = videoReadRequest ? videoReadAddress : readPendingAddress;
    assign readConsume     = (nextState == READ_ADDR);
    assign writeStart      = (state == IDLE) && (nextState == WRITE_SETUP);

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (readWanted) begin
                    nextState = READ_ADDR;
                end else if (memoryWriteRequest) begin
                    nextState = WRITE_SETUP;
                end
            end
            READ_ADDR:   nextState = READ_DATA;
            READ_DATA:   nextState = IDLE;
            WRITE_SETUP: nextState = WRITE_PULSE;
            WRITE_PULSE: begin
                if (pulseCount == LAST_PULSE) begin
                    nextState = WRITE_HOLD;
                end
            end
            WRITE_HOLD:  nextState = WRITE_DONE;
            WRITE_DONE:  nextState = readWanted ? READ_ADDR : IDLE;
            default:     nextState = IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered, so the pins are glitch-free Moore outputs.
    always_comb begin
        chipEnableNext_n   = 1'b1;
        outputEnableNext_n = 1'b1;
        writeEnableNext_n  = 1'b1;
        dataOutEnableNext  = 1'b0;
        writeCompleteNext  = 1'b0;
        case (nextState)
            READ_ADDR, READ_DATA: begin
                chipEnableNext_n   = 1'b0;
                outputEnableNext_n = 1'b0;
            end
            WRITE_SETUP, WRITE_HOLD: begin
                chipEnableNext_n  = 1'b0;
                dataOutEnableNext = 1'b1;
            end
            WRITE_PULSE: begin
                chipEnableNext_n  = 1'b0;
                writeEnableNext_n = 1'b0;
                dataOutEnableNext = 1'b1;
            end
            WRITE_DONE: begin
                writeCompleteNext = 1'b1;
            end
            default: begin
                chipEnableNext_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            pulseCount          <= '0;
            readPending         <= 1'b0;
            readPendingAddress  <= '0;
            videoReadData       <= '0;
            videoReadValid      <= 1'b0;
            videoReadOverrun    <= 1'b0;
            memoryWriteComplete <= 1'b0;
            sramAddress         <= '0;
            sramDataOut         <= '0;
            sramDataOutEnable   <= 1'b0;
            sramChipEnable_n    <= 1'b1;
            sramOutputEnable_n  <= 1'b1;
            sramWriteEnable_n   <= 1'b1;
        end else begin
            state               <= nextState;
            memoryWriteComplete <= writeCompleteNext;
            sramDataOutEnable   <= dataOutEnableNext;
            sramChipEnable_n    <= chipEnableNext_n;
            sramOutputEnable_n  <= outputEnableNext_n;
            sramWriteEnable_n   <= writeEnableNext_n;

            if (state == WRITE_PULSE) begin
                pulseCount <= pulseCount + 3'd1;
            end else begin
                pulseCount <= '0;
            end

            if (readConsume) begin
                sramAddress <= readAddressNext;
            end else if (writeStart) begin
                sramAddress <= memoryAddress;
                sramDataOut <= memoryWriteData;
            end

            // A second request while one is still waiting replaces it and is flagged.
            if (readConsume) begin
                readPending <= 1'b0;
            end else if (videoReadRequest) begin
                readPending        <= 1'b1;
                readPendingAddress <= videoReadAddress;
                if (readPending) begin
                    videoReadOverrun <= 1'b1;
                end
            end

            videoReadValid <= (state == READ_DATA);
            if (state == READ_DATA) begin
                videoReadData <= sramDataIn;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        videoReadRequest;
    logic [16:0] videoReadAddress;
    logic [7:0]  videoReadData;
    logic        videoReadValid;
    logic        videoReadOverrun;
    logic        memoryWriteRequest;
    logic [16:0] memoryAddress;
    logic [7:0]  memoryWriteData;
    logic        memoryWriteComplete;
    logic [16:0] sramAddress;
    logic [7:0]  sramDataOut;
    logic        sramDataOutEnable;
    logic [7:0]  sramDataIn;
    logic        sramChipEnable_n;
    logic        sramOutputEnable_n;
    logic        sramWriteEnable_n;

    int assertCount = 0;
    int failCount   = 0;

    // Strobe vector order: {CE_n, OE_n, WE_n, dataOutEnable}
    localparam logic [3:0] S_IDLE  = 4'b1110;
    localparam logic [3:0] S_READ  = 4'b0010;
    localparam logic [3:0] S_WSET  = 4'b0111;
    localparam logic [3:0] S_WPUL  = 4'b0101;

    sram_arbiter #(
        .ADDRESS_WIDTH(17),
        .DATA_WIDTH(8),
        .WRITE_CYCLES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .videoReadRequest(videoReadRequest),
        .videoReadAddress(videoReadAddress),
        .videoReadData(videoReadData),
        .videoReadValid(videoReadValid),
        .videoReadOverrun(videoReadOverrun),
        .memoryWriteRequest(memoryWriteRequest),
        .memoryAddress(memoryAddress),
        .memoryWriteData(memoryWriteData),
        .memoryWriteComplete(memoryWriteComplete),
        .sramAddress(sramAddress),
        .sramDataOut(sramDataOut),
        .sramDataOutEnable(sramDataOutEnable),
        .sramDataIn(sramDataIn),
        .sramChipEnable_n(sramChipEnable_n),
        .sramOutputEnable_n(sramOutputEnable_n),
        .sramWriteEnable_n(sramWriteEnable_n)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {sramChipEnable_n, sramOutputEnable_n, sramWriteEnable_n, sramDataOutEnable};
    endfunction

    initial begin
        reset              = 1'b1;
        videoReadRequest   = 1'b0;
        videoReadAddress   = '0;
        memoryWriteRequest = 1'b0;
        memoryAddress      = '0;
        memoryWriteData    = '0;
        sramDataIn         = '0;
        step();
        step();
        check("reset_strobes", 32'(strobes()), 32'(S_IDLE));
        check("reset_addr", 32'(sramAddress), 32'h0);
        check("reset_dout", 32'(sramDataOut), 32'h0);
        check("reset_rdata", 32'(videoReadData), 32'h0);
        check("reset_valid", 32'(videoReadValid), 32'h0);
        check("reset_overrun", 32'(videoReadOverrun), 32'h0);
        check("reset_complete", 32'(memoryWriteComplete), 32'h0);
        reset = 1'b0;
        step();

        // Plain read at 0x1_2345
        videoReadRequest = 1'b1;
        videoReadAddress = 17'h1_2345;
        sramDataIn       = 8'hA5;
        step();
        videoReadRequest = 1'b0;
        check("rd_c1_strobes", 32'(strobes()), 32'(S_READ));
        check("rd_c1_addr", 32'(sramAddress), 32'h1_2345);
        check("rd_c1_valid", 32'(videoReadValid), 32'h0);
        step();
        check("rd_c2_strobes", 32'(strobes()), 32'(S_READ));
        step();
        check("rd_c3_strobes", 32'(strobes()), 32'(S_IDLE));
        check("rd_c3_valid", 32'(videoReadValid), 32'h1);
        check("rd_c3_data", 32'(videoReadData), 32'hA5);
        step();
        check("rd_c4_valid", 32'(videoReadValid), 32'h0);
        check("rd_c4_data_hold", 32'(videoReadData), 32'hA5);

        // Plain write at 0x0_0201
        memoryWriteRequest = 1'b1;
        memoryAddress      = 17'h0_0201;
        memoryWriteData    = 8'h3C;
        step();
        check("wr_c1_strobes", 32'(strobes()), 32'(S_WSET));
        check("wr_c1_addr", 32'(sramAddress), 32'h0_0201);
        check("wr_c1_dout", 32'(sramDataOut), 32'h3C);
        step();
        check("wr_c2_strobes", 32'(strobes()), 32'(S_WPUL));
        step();
        check("wr_c3_strobes", 32'(strobes()), 32'(S_WPUL));
        step();
        check("wr_c4_strobes", 32'(strobes()), 32'(S_WSET));
        check("wr_c4_complete", 32'(memoryWriteComplete), 32'h0);
        step();
        check("wr_c5_complete", 32'(memoryWriteComplete), 32'h1);
        check("wr_c5_strobes", 32'(strobes()), 32'(S_IDLE));
        memoryWriteRequest = 1'b0;
        step();
        check("wr_c6_complete", 32'(memoryWriteComplete), 32'h0);
        check("wr_c6_strobes", 32'(strobes()), 32'(S_IDLE));
        step();
        check("wr_c7_no_rewrite", 32'(strobes()), 32'(S_IDLE));

        // Simultaneous read and write: read first
        videoReadRequest   = 1'b1;
        videoReadAddress   = 17'h1_ABCD;
        sramDataIn         = 8'h66;
        memoryWriteRequest = 1'b1;
        memoryAddress      = 17'h0_0777;
        memoryWriteData    = 8'h5A;
        step();
        videoReadRequest = 1'b0;
        check("mix_c1_strobes", 32'(strobes()), 32'(S_READ));
        check("mix_c1_addr", 32'(sramAddress), 32'h1_ABCD);
        step();
        check("mix_c2_strobes", 32'(strobes()), 32'(S_READ));
        step();
        check("mix_c3_strobes", 32'(strobes()), 32'(S_IDLE));
        check("mix_c3_valid", 32'(videoReadValid), 32'h1);
        check("mix_c3_data", 32'(videoReadData), 32'h66);
        step();
        check("mix_c4_strobes", 32'(strobes()), 32'(S_WSET));
        check("mix_c4_addr", 32'(sramAddress), 32'h0_0777);
        check("mix_c4_dout", 32'(sramDataOut), 32'h5A);
        step();
        check("mix_c5_strobes", 32'(strobes()), 32'(S_WPUL));
        step();
        check("mix_c6_strobes", 32'(strobes()), 32'(S_WPUL));
        step();
        check("mix_c7_strobes", 32'(strobes()), 32'(S_WSET));
        step();
        check("mix_c8_complete", 32'(memoryWriteComplete), 32'h1);
        memoryWriteRequest = 1'b0;
        step();
        check("mix_c9_complete", 32'(memoryWriteComplete), 32'h0);

        // Read pulse during WRITE_PULSE
        memoryWriteRequest = 1'b1;
        memoryAddress      = 17'h0_0100;
        memoryWriteData    = 8'h11;
        step();
        step();
        check("rdw_c2_strobes", 32'(strobes()), 32'(S_WPUL));
        videoReadRequest = 1'b1;
        videoReadAddress = 17'h0_F0F0;
        sramDataIn       = 8'h99;
        step();
        videoReadRequest = 1'b0;
        check("rdw_c3_strobes", 32'(strobes()), 32'(S_WPUL));
        step();
        check("rdw_c4_strobes", 32'(strobes()), 32'(S_WSET));
        step();
        check("rdw_c5_complete", 32'(memoryWriteComplete), 32'h1);
        memoryWriteRequest = 1'b0;
        step();
        check("rdw_c6_strobes", 32'(strobes()), 32'(S_READ));
        check("rdw_c6_addr", 32'(sramAddress), 32'h0_F0F0);
        check("rdw_c6_complete", 32'(memoryWriteComplete), 32'h0);
        step();
        check("rdw_c7_strobes", 32'(strobes()), 32'(S_READ));
        step();
        check("rdw_c8_valid", 32'(videoReadValid), 32'h1);
        check("rdw_c8_data", 32'(videoReadData), 32'h99);
        check("rdw_c8_overrun", 32'(videoReadOverrun), 32'h0);

        // Two reads during a write: second wins, overrun latches
        memoryWriteRequest = 1'b1;
        memoryAddress      = 17'h0_0200;
        memoryWriteData    = 8'h22;
        step();
        videoReadRequest = 1'b1;
        videoReadAddress = 17'h1_1111;
        step();
        videoReadAddress = 17'h0_2222;
        sramDataIn       = 8'h77;
        step();
        videoReadRequest = 1'b0;
        check("ovr_c3_overrun", 32'(videoReadOverrun), 32'h1);
        step();
        step();
        check("ovr_c5_complete", 32'(memoryWriteComplete), 32'h1);
        memoryWriteRequest = 1'b0;
        step();
        check("ovr_c6_strobes", 32'(strobes()), 32'(S_READ));
        check("ovr_c6_addr", 32'(sramAddress), 32'h0_2222);
        step();
        step();
        check("ovr_c8_valid", 32'(videoReadValid), 32'h1);
        check("ovr_c8_data", 32'(videoReadData), 32'h77);
        step();
        check("ovr_c9_strobes", 32'(strobes()), 32'(S_IDLE));
        step();
        check("ovr_c10_strobes", 32'(strobes()), 32'(S_IDLE));
        check("ovr_c10_sticky", 32'(videoReadOverrun), 32'h1);

        // Reset in the first WRITE_PULSE cycle, with a read pending
        memoryWriteRequest = 1'b1;
        memoryAddress      = 17'h0_0300;
        memoryWriteData    = 8'h33;
        step();
        videoReadRequest = 1'b1;
        videoReadAddress = 17'h0_4444;
        step();
        videoReadRequest = 1'b0;
        check("rst_c2_strobes", 32'(strobes()), 32'(S_WPUL));
        reset = 1'b1;
        step();
        check("rst_c3_strobes", 32'(strobes()), 32'(S_IDLE));
        check("rst_c3_complete", 32'(memoryWriteComplete), 32'h0);
        check("rst_c3_overrun", 32'(videoReadOverrun), 32'h0);
        check("rst_c3_addr", 32'(sramAddress), 32'h0);
        reset              = 1'b0;
        memoryWriteRequest = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("rst_after_%0d_complete", i), 32'(memoryWriteComplete), 32'h0);
            check($sformatf("rst_after_%0d_strobes", i), 32'(strobes()), 32'(S_IDLE));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
